ooo_read_slave: RTL and testbench

Out-of-order AXI-style read slave model that sits directly downstream of the reorder buffer's master-side AR/R ports. It consumes the AR stream, keeps one outstanding slot per 4-bit ID (16 slots) and returns R beats after an ID-dependent latency. Higher IDs return sooner, so responses are deliberately reordered. Use it as the memory-side stimulus for reorder-buffer integration benches and as a reusable simulation/FPGA response generator.

---
 rtl/ooo_read_slave.sv | 116 +++++++++++
 tb/tb_ooo_read_slave.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ooo_read_slave.sv
// ooo_read_slave: out-of-order AXI-style read slave with one slot per ID and ID-dependent latency
module ooo_read_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int MIN_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            s_arid_i,
    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,
    output logic [DATA_WIDTH-1:0] s_rdata_o,
    output logic [3:0]            s_rid_o,
    output logic                  s_rvalid_o,
    input  logic                  s_rready_i,
    output logic [4:0]            outstanding_o
);
    typedef enum logic {R_IDLE, R_VALID} r_state_e;

    r_state_e              state_q, state_d;
    logic [15:0]           busy_q, busy_d, issued_q, issued_d;
    logic [4:0]            cnt_q [16];
    logic [4:0]            cnt_d [16];
    logic [3:0]            seq_q [16];
    logic [3:0]            seq_d [16];
    logic [3:0]            seq_ctr_q, seq_ctr_d, rr_q, rr_d, rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [4:0]            out_q, out_d;
    logic                  ar_hs, r_hs, found;
    logic [3:0]            pick, idx;

    assign s_arready_o   = ~busy_q[s_arid_i];
    assign ar_hs         = s_arvalid_i && s_arready_o;
    assign r_hs          = (state_q == R_VALID) && s_rready_i;
    assign s_rvalid_o    = (state_q == R_VALID);
    assign s_rid_o       = rid_q;
    assign s_rdata_o     = rdata_q;
    assign outstanding_o = out_q;

    // Round-robin pick: first eligible slot starting at rr
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        idx   = rr_q;
        for (int i = 0; i < 16; i++) begin
            idx = rr_q + i[3:0];
            if (!found && busy_q[idx] && cnt_q[idx] == 5'd0 && !issued_q[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Next state: countdown, free on R handshake, load output, accept AR
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        issued_d  = issued_q;
        cnt_d     = cnt_q;
        seq_d     = seq_q;
        seq_ctr_d = seq_ctr_q;
        rr_d      = rr_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        out_d     = out_q + 5'(ar_hs) - 5'(r_hs);
        for (int k = 0; k < 16; k++)
            if (busy_q[k] && cnt_q[k] != 5'd0) cnt_d[k] = cnt_q[k] - 5'd1;
        if (r_hs) begin
            busy_d[rid_q]   = 1'b0;
            issued_d[rid_q] = 1'b0;
            rr_d            = rid_q + 4'd1;
            state_d         = R_IDLE;
        end
        if ((state_q == R_IDLE || r_hs) && found) begin
            state_d        = R_VALID;
            rid_d          = pick;
            rdata_d        = DATA_WIDTH'({seq_q[pick], pick});
            issued_d[pick] = 1'b1;
        end
        if (ar_hs) begin
            busy_d[s_arid_i]   = 1'b1;
            issued_d[s_arid_i] = 1'b0;
            cnt_d[s_arid_i]    = 5'(MIN_LAT) + {1'b0, ~s_arid_i};
            seq_d[s_arid_i]    = seq_ctr_q;
            seq_ctr_d          = seq_ctr_q + 4'd1;
        end
    end

    // State registers with asynchronous reset that drops all in-flight requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= R_IDLE;
            busy_q    <= '0;
            issued_q  <= '0;
            seq_ctr_q <= '0;
            rr_q      <= '0;
            rid_q     <= '0;
            rdata_q   <= '0;
            out_q     <= '0;
            for (int k = 0; k < 16; k++) begin
                cnt_q[k] <= '0;
                seq_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            issued_q  <= issued_d;
            seq_ctr_q <= seq_ctr_d;
            rr_q      <= rr_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
            seq_q     <= seq_d;
        end
    end
endmodule

// File: tb/tb_ooo_read_slave.sv
// tb_ooo_read_slave: directed stimulus with a response scoreboard for ooo_read_slave
module tb_ooo_read_slave;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] s_arid_i = '0;
    logic       s_arvalid_i = 1'b0;
    logic       s_arready_o;
    logic [7:0] s_rdata_o;
    logic [3:0] s_rid_o;
    logic       s_rvalid_o;
    logic       s_rready_i = 1'b0;
    logic [4:0] outstanding_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [11:0] exp_q [$];

    ooo_read_slave #(.DATA_WIDTH(8), .MIN_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .s_arid_i(s_arid_i), .s_arvalid_i(s_arvalid_i),
        .s_arready_o(s_arready_o), .s_rdata_o(s_rdata_o), .s_rid_o(s_rid_o),
        .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i), .outstanding_o(outstanding_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every R handshake must match the oldest expected beat
    always @(negedge clk) begin
        if (rst_n && s_rvalid_o && s_rready_i) begin
            if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
            else chk("r_beat", int'({s_rid_o, s_rdata_o}), int'(exp_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_arvalid_i = 1'b0;
        s_rready_i = 1'b0;
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic wait_valid(input string name, input int exp_cyc);
        while (!s_rvalid_o && cyc < 200) step();
        chk(name, cyc, exp_cyc);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((outstanding_o != 0 || exp_q.size() != 0) && n < 300) begin
            step();
            n++;
        end
        chk({name, "_outstanding"}, int'(outstanding_o), 0);
        chk({name, "_queue"}, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int bad;
        #1;
        chk("rst_rvalid", int'(s_rvalid_o), 0);
        chk("rst_outstanding", int'(outstanding_o), 0);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            s_arid_i = 4'(k);
            #0.1;
            if (!s_arready_o) bad++;
        end
        chk("rst_arready_all", bad, 0);

        // single request: ID 15 -> beat in cycle 4
        do_reset();
        s_arid_i = 4'd15; s_arvalid_i = 1'b1; s_rready_i = 1'b1;
        exp_q.push_back({4'd15, 8'h0F});
        step();
        s_arvalid_i = 1'b0;
        chk("single_outstanding1", int'(outstanding_o), 1);
        wait_valid("single_latency", 4);
        chk("single_rid", int'(s_rid_o), 15);
        step();
        chk("single_outstanding0", int'(outstanding_o), 0);
        wait_idle("single");

        // reordering: ID 0 then ID 15, ID 15 returns first
        do_reset();
        s_arid_i = 4'd0; s_arvalid_i = 1'b1; s_rready_i = 1'b1;
        exp_q.push_back({4'd15, 8'h1F});
        exp_q.push_back({4'd0, 8'h00});
        step();
        s_arid_i = 4'd15;
        step();
        s_arvalid_i = 1'b0;
        wait_valid("reorder_first_cycle", 5);
        chk("reorder_first_rid", int'(s_rid_o), 15);
        step();
        wait_valid("reorder_second_cycle", 19);
        chk("reorder_second_rid", int'(s_rid_o), 0);
        wait_idle("reorder");

        // duplicate ID 3 refused until after its R handshake
        do_reset();
        s_arid_i = 4'd3; s_arvalid_i = 1'b1;
        exp_q.push_back({4'd3, 8'h03});
        step();
        bad = 0;
        while (!s_rvalid_o && cyc < 200) begin
            if (s_arready_o) bad++;
            step();
        end
        chk("dup_refused", bad, 0);
        chk("dup_first_cycle", cyc, 16);
        s_rready_i = 1'b1;
        #0.1;
        chk("dup_same_cycle_free", int'(s_arready_o), 0);
        exp_q.push_back({4'd3, 8'h13});
        step();
        chk("dup_accept_next", int'(s_arready_o), 1);
        step();
        s_arvalid_i = 1'b0;
        chk("dup_outstanding", int'(outstanding_o), 1);
        wait_valid("dup_second_cycle", 33);
        wait_idle("dup");

        // backpressure: 3 eligible slots, rready low 10 cycles, then RR order 15,13,14
        do_reset();
        s_arvalid_i = 1'b1;
        s_arid_i = 4'd15; step();
        s_arid_i = 4'd14; step();
        s_arid_i = 4'd13; step();
        s_arvalid_i = 1'b0;
        exp_q.push_back({4'd15, 8'h0F});
        exp_q.push_back({4'd13, 8'h2D});
        exp_q.push_back({4'd14, 8'h1E});
        wait_valid("bp_first_cycle", 4);
        bad = 0;
        repeat (10) begin
            if (!s_rvalid_o || s_rid_o != 4'd15 || s_rdata_o != 8'h0F) bad++;
            step();
        end
        chk("bp_hold_stable", bad, 0);
        s_rready_i = 1'b1;
        step();
        chk("bp_beat2", int'({s_rvalid_o, s_rid_o}), int'({1'b1, 4'd13}));
        step();
        chk("bp_beat3", int'({s_rvalid_o, s_rid_o}), int'({1'b1, 4'd14}));
        step();
        chk("bp_after", int'(s_rvalid_o), 0);
        wait_idle("bp");

        // full: 16 outstanding, all refused; seq wraps to 0 for the next accept
        do_reset();
        s_arvalid_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            s_arid_i = 4'(k);
            exp_q.push_back({4'(k), 8'(k * 17)});
            step();
        end
        s_arvalid_i = 1'b0;
        chk("full_outstanding", int'(outstanding_o), 16);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            s_arid_i = 4'(k);
            #0.1;
            if (s_arready_o) bad++;
        end
        chk("full_arready_all0", bad, 0);
        s_rready_i = 1'b1;
        wait_valid("full_first_cycle", 19);
        chk("full_first_rid", int'(s_rid_o), 0);
        step();
        s_arid_i = 4'd0; s_arvalid_i = 1'b1;
        #0.1;
        chk("full_reaccept", int'(s_arready_o), 1);
        exp_q.push_back({4'd0, 8'h00});
        step();
        s_arvalid_i = 1'b0;
        wait_idle("full");

        // asynchronous reset mid-operation
        do_reset();
        s_arvalid_i = 1'b1;
        for (int k = 15; k >= 11; k--) begin
            s_arid_i = 4'(k);
            step();
        end
        s_arvalid_i = 1'b0;
        repeat (3) step();
        chk("mid_pre_valid", int'(s_rvalid_o), 1);
        chk("mid_pre_outstanding", int'(outstanding_o), 5);
        #2;
        rst_n = 1'b0;
        s_arid_i = 4'd15;
        #1;
        chk("mid_rst_rvalid", int'(s_rvalid_o), 0);
        chk("mid_rst_rid_rdata", int'({s_rid_o, s_rdata_o}), 0);
        chk("mid_rst_outstanding", int'(outstanding_o), 0);
        chk("mid_rst_arready", int'(s_arready_o), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
        s_rready_i = 1'b1;
        bad = 0;
        repeat (40) begin
            if (s_rvalid_o) bad++;
            step();
        end
        chk("mid_no_stale", bad, 0);
        bad = 0;
        s_arvalid_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            s_arid_i = 4'(k);
            #0.1;
            if (!s_arready_o) bad++;
            exp_q.push_back({4'(k), 8'(k * 17)});
            step();
        end
        s_arvalid_i = 1'b0;
        chk("mid_accept_all", bad, 0);
        wait_idle("mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
